cnn_run_ctrl: RTL and testbench
===============================

// Module: cnn_run_ctrl
// PURPOSE
//  Board-level run controller between raw push-button and CNN core. Debounces start_btn, issues
//  one-cycle cnn_start pulses, runs NUM_RUNS back-to-back inferences per press, latches each result
//  onto led_result, counts completed runs. Optional watchdog flags a core that never asserts done.
// PARAMETERS
//  RESULT_W      8        width of cnn_result / led_result
//  DEBOUNCE_CYC  1000000  consecutive stable cycles to accept a button level (>=2)
//  NUM_RUNS      1        inferences launched per accepted press (>=1)
//  TIMEOUT_CYC   65536    WAIT cycles before timeout (only with CNN_CTRL_WDT_EN)
//  CNT_W         16       width of run_cnt
// PORTS
//  clk_100m    in   1         system clock
//  rst_btn_n   in   1         reset, asynchronous assert, active-low
//  start_btn   in   1         raw asynchronous button, active-high
//  cnn_start   out  1         one-cycle launch pulse to CNN core
//  cnn_done    in   1         core completion strobe; sampled only in WAIT
//  cnn_result  in   RESULT_W  core result, valid in the cnn_done cycle
//  led_result  out  RESULT_W  last latched result
//  busy        out  1         high from LAUNCH until return to IDLE/ERR
//  run_cnt     out  CNT_W     total completed runs since reset, wraps at 2^CNT_W
//  err_timeout out  1         watchdog fired (0 when macro absent)
// BEHAVIOUR
//  Reset (rst_btn_n=0, async): state=IDLE; all outputs 0; debounced level 0; counters 0.
//  Button path: 2-FF sync -> counter; debounced level changes only after DEBOUNCE_CYC consecutive
//   cycles of differing synced level; counter clears on any bounce. Press = debounced 0->1 edge.
//  FSM states: IDLE, LAUNCH, WAIT, LATCH, ERR.
//   IDLE  : press -> LAUNCH.  Press in any other state ignored (not queued).
//   LAUNCH: cnn_start=1 this cycle only; runs_left loaded NUM_RUNS on first launch of a press; -> WAIT.
//   WAIT  : cnn_done=1 -> LATCH. With watchdog, wdt counts WAIT cycles; wdt==TIMEOUT_CYC-1 and no done -> ERR.
//           cnn_done wins over timeout in the same cycle.
//   LATCH : led_result<=cnn_result captured in the WAIT done cycle (visible cycle after done);
//           run_cnt+1; runs_left-1; runs_left>0 -> LAUNCH else IDLE.
//   ERR   : err_timeout=1, busy=0, led_result held; next press -> IDLE clears err_timeout (no launch;
//           a further press starts a new sequence).
//  Latency: press edge cycle t -> cnn_start at t+1. done at t -> led_result valid t+1; next cnn_start
//   at t+2 if runs remain; busy falls at t+2 on last run.
//  cnn_done outside WAIT ignored. busy=1 in LAUNCH/WAIT/LATCH.
//  Reset mid-run: immediate IDLE, cnn_start deasserts asynchronously, led_result/run_cnt cleared.
// CONFIGURATION
//  CNN_CTRL_WDT_EN defined: watchdog counter, ERR state reachable, err_timeout driven as above.
//  Undefined: no watchdog logic, WAIT holds indefinitely, ERR unreachable, err_timeout tied 0.
// STRUCTURE
//  Package cnn_ctrl_pkg: state encoding localparams (IDLE..ERR), default DEBOUNCE/TIMEOUT constants.
//  Sub-module btn_debounce (sync + stable counter + rising-edge pulse), parameter DEBOUNCE_CYC.
//  Top: FSM, runs_left, run_cnt, result latch, optional watchdog.
// TESTING  (bench: DEBOUNCE_CYC=4, NUM_RUNS=3, TIMEOUT_CYC=100, RESULT_W=8)
//  1 Bounce 1-0-1-0 then hold 1 for 10 cycles -> exactly one cnn_start pulse, 6-7 cycles after stable-high start.
//  2 Press; core returns done with results 5,7,9 at 20 cycles each -> 3 cnn_start pulses, led_result 5->7->9,
//    run_cnt=3, busy low 2 cycles after third done.
//  3 Second press during WAIT of run 1 -> ignored; total cnn_start count stays 3, run_cnt=3.
//  4 WDT_EN: no done -> err_timeout=1 exactly 100 cycles after entering WAIT, busy=0, led_result unchanged;
//    press clears err; next press launches normally. Without macro: no done -> busy stays 1, err_timeout=0.
//  5 done asserted in same cycle as cnn_start or while IDLE -> ignored, led_result unchanged.
//  6 rst_btn_n low mid-WAIT (between clock edges) -> outputs 0 immediately, state IDLE, press relaunches.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN run controller: FSM state type and default timing constants.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LATCH  = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;
    localparam int unsigned DEF_TIMEOUT_CYC  = 65536;

endpackage

// File: rtl/cnn_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level counter, and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          press_q;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive differing samples; any bounce restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            cnt     <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync_q2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level   <= sync_q2;
                    cnt     <= '0;
                    press_q <= sync_q2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cnn_run_ctrl.sv
// Board-level run controller: debounced start button launches NUM_RUNS back-to-back
// inferences, latches each result onto led_result and counts completed runs.
// Optional watchdog enabled by defining CNN_CTRL_WDT_EN.
module cnn_run_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned RESULT_W     = 8,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned NUM_RUNS     = 1,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk_100m,
    input  logic                rst_btn_n,
    input  logic                start_btn,
    output logic                cnn_start,
    input  logic                cnn_done,
    input  logic [RESULT_W-1:0] cnn_result,
    output logic [RESULT_W-1:0] led_result,
    output logic                busy,
    output logic [CNT_W-1:0]    run_cnt,
    output logic                err_timeout
);

    localparam int unsigned RUNS_W = $clog2(NUM_RUNS + 1);

    // Parameter sanity checks at elaboration.
    if (DEBOUNCE_CYC < 2) begin : g_chk_deb
        $error("DEBOUNCE_CYC must be >= 2");
    end
    if (NUM_RUNS < 1) begin : g_chk_runs
        $error("NUM_RUNS must be >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_to
        $error("TIMEOUT_CYC must be >= 1");
    end

    state_t              state;
    state_t              state_next;
    logic                press;
    logic                wdt_fire;
    logic [RUNS_W-1:0]   runs_left;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk     (clk_100m),
        .rst_n   (rst_btn_n),
        .btn_raw (start_btn),
        .press   (press)
    );

`ifdef CNN_CTRL_WDT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDT_W-1:0] wdt;

    // Count cycles spent waiting for the core; cleared whenever WAIT is left.
    always_ff @(posedge clk_100m or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            wdt <= '0;
        end else if (state == ST_WAIT && !cnn_done) begin
            wdt <= wdt + WDT_W'(1);
        end else begin
            wdt <= '0;
        end
    end

    assign wdt_fire    = (wdt == WDT_W'(TIMEOUT_CYC - 1));
    assign err_timeout = (state == ST_ERR);
`else
    assign wdt_fire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_100m or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; done has priority over the watchdog in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (press) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (cnn_done)      state_next = ST_LATCH;
                else if (wdt_fire) state_next = ST_ERR;
            end
            ST_LATCH:  state_next = (runs_left != '0) ? ST_LAUNCH : ST_IDLE;
            ST_ERR:    if (press) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Run bookkeeping and result latch. Result, run count and remaining runs all update on the
    // done edge so they are visible during LATCH, where the relaunch decision reads runs_left.
    always_ff @(posedge clk_100m or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            led_result <= '0;
            run_cnt    <= '0;
            runs_left  <= '0;
        end else begin
            if (state == ST_IDLE && press) begin
                runs_left <= RUNS_W'(NUM_RUNS);
            end
            if (state == ST_WAIT && cnn_done) begin
                led_result <= cnn_result;
                run_cnt    <= run_cnt + CNT_W'(1);
                runs_left  <= runs_left - RUNS_W'(1);
            end
        end
    end

    assign cnn_start = (state == ST_LAUNCH);
    assign busy      = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_LATCH);

endmodule

// File: tb/tb_cnn_run_ctrl.sv
// Directed self-checking bench for cnn_run_ctrl with a result scoreboard.
// Works with or without CNN_CTRL_WDT_EN defined.
module tb_cnn_run_ctrl;

    localparam int unsigned RW = 8;
    localparam int unsigned CW = 16;

    logic          clk_100m = 1'b0;
    logic          rst_btn_n;
    logic          start_btn;
    logic          cnn_start;
    logic          cnn_done;
    logic [RW-1:0] cnn_result;
    logic [RW-1:0] led_result;
    logic          busy;
    logic [CW-1:0] run_cnt;
    logic          err_timeout;

    int            total = 0;
    int            bad = 0;
    int            start_cnt = 0;
    int            exp_runs = 0;
    logic [RW-1:0] exp_led = '0;
    logic [RW-1:0] sb[$];

    cnn_run_ctrl #(
        .RESULT_W     (8),
        .DEBOUNCE_CYC (4),
        .NUM_RUNS     (3),
        .TIMEOUT_CYC  (100),
        .CNT_W        (16)
    ) dut (
        .clk_100m    (clk_100m),
        .rst_btn_n   (rst_btn_n),
        .start_btn   (start_btn),
        .cnn_start   (cnn_start),
        .cnn_done    (cnn_done),
        .cnn_result  (cnn_result),
        .led_result  (led_result),
        .busy        (busy),
        .run_cnt     (run_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk_100m = ~clk_100m;

    // Count launch pulses seen by the core.
    always @(negedge clk_100m) begin
        if (rst_btn_n === 1'b1 && cnn_start === 1'b1) start_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a cnn_start pulse; returns the number of negedges waited.
    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_100m);
            if (cnn_start === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(lat != 0), 32'd1);
    endtask

    task automatic press_and_start(input string tag);
        int lat;
        start_btn = 1'b1;
        wait_start(tag, lat);
        start_btn = 1'b0;
    endtask

    // Answer the current run after 'delay' cycles; optionally bounce the button during WAIT.
    task automatic finish_run(input logic [RW-1:0] res, input int delay, input bit bump, input bit last);
        for (int i = 0; i < delay; i++) begin
            if (bump) start_btn = (i < 10);
            @(negedge clk_100m);
        end
        start_btn  = 1'b0;
        cnn_done   = 1'b1;
        cnn_result = res;
        sb.push_back(res);
        @(negedge clk_100m);
        cnn_done   = 1'b0;
        cnn_result = '0;
        exp_runs++;
        check("sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) exp_led = sb.pop_front();
        check("led_result", 32'(led_result), 32'(exp_led));
        check("run_cnt", 32'(run_cnt), 32'(exp_runs));
        check("busy_latch", 32'(busy), 32'd1);
        @(negedge clk_100m);
        if (last) begin
            check("busy_fall", 32'(busy), 32'd0);
            check("no_relaunch", 32'(cnn_start), 32'd0);
        end else begin
            check("relaunch_t2", 32'(cnn_start), 32'd1);
        end
    endtask

    task automatic run_sequence(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                                input logic [RW-1:0] r2, input bit bump);
        finish_run(r0, 20, bump, 1'b0);
        finish_run(r1, 20, 1'b0, 1'b0);
        finish_run(r2, 20, 1'b0, 1'b1);
    endtask

    initial begin
        int s0;
        int lat;
        int et;

        rst_btn_n  = 1'b0;
        start_btn  = 1'b0;
        cnn_done   = 1'b0;
        cnn_result = '0;
        #2;
        check("rst_cnn_start", 32'(cnn_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_led", 32'(led_result), 32'd0);
        check("rst_run_cnt", 32'(run_cnt), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        repeat (3) @(negedge clk_100m);
        rst_btn_n = 1'b1;
        repeat (3) @(negedge clk_100m);

        // 1: bounce then stable press
        s0 = start_cnt;
        start_btn = 1'b1; @(negedge clk_100m);
        start_btn = 1'b0; @(negedge clk_100m);
        start_btn = 1'b1; @(negedge clk_100m);
        start_btn = 1'b0; @(negedge clk_100m);
        start_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_100m);
            if (cnn_start === 1'b1 && lat == 0) lat = k;
        end
        start_btn = 1'b0;
        check("t1_latency", 32'(lat >= 6 && lat <= 7), 32'd1);
        #1;
        check("t1_one_pulse", 32'(start_cnt - s0), 32'd1);
        finish_run(8'h01, 5, 1'b0, 1'b0);
        finish_run(8'h02, 20, 1'b0, 1'b0);
        finish_run(8'h03, 20, 1'b0, 1'b1);
        repeat (10) @(negedge clk_100m);

        // 2: three runs with results 5, 7, 9
        s0 = start_cnt;
        press_and_start("t2");
        run_sequence(8'd5, 8'd7, 8'd9, 1'b0);
        #1;
        check("t2_starts", 32'(start_cnt - s0), 32'd3);
        repeat (10) @(negedge clk_100m);

        // 3: press during WAIT of run 1 is ignored
        s0 = start_cnt;
        press_and_start("t3");
        run_sequence(8'h11, 8'h22, 8'h33, 1'b1);
        repeat (10) @(negedge clk_100m);
        check("t3_starts", 32'(start_cnt - s0), 32'd3);

        // 5: done while IDLE and in the launch cycle are ignored
        s0 = start_cnt;
        cnn_done = 1'b1; cnn_result = 8'hDD;
        repeat (3) @(negedge clk_100m);
        cnn_done = 1'b0; cnn_result = '0;
        check("t5_idle_led", 32'(led_result), 32'(exp_led));
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_run_cnt", 32'(run_cnt), 32'(exp_runs));
        press_and_start("t5");
        cnn_done = 1'b1; cnn_result = 8'hEE;
        @(negedge clk_100m);
        cnn_done = 1'b0; cnn_result = '0;
        check("t5_launch_led", 32'(led_result), 32'(exp_led));
        check("t5_launch_busy", 32'(busy), 32'd1);
        check("t5_launch_run_cnt", 32'(run_cnt), 32'(exp_runs));
        finish_run(8'h44, 10, 1'b0, 1'b0);
        finish_run(8'h55, 20, 1'b0, 1'b0);
        finish_run(8'h66, 20, 1'b0, 1'b1);
        #1;
        check("t5_starts", 32'(start_cnt - s0), 32'd3);
        repeat (10) @(negedge clk_100m);

        // 4: core never answers
        s0 = start_cnt;
        press_and_start("t4");
`ifdef CNN_CTRL_WDT_EN
        et = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk_100m);
            if (err_timeout === 1'b1) begin
                et = k;
                break;
            end
        end
        check("t4_err_cycle", 32'(et), 32'd101);
        check("t4_err_busy", 32'(busy), 32'd0);
        check("t4_err_led", 32'(led_result), 32'(exp_led));
        check("t4_err_run_cnt", 32'(run_cnt), 32'(exp_runs));
        repeat (10) @(negedge clk_100m);
        start_btn = 1'b1;
        repeat (12) @(negedge clk_100m);
        start_btn = 1'b0;
        check("t4_err_cleared", 32'(err_timeout), 32'd0);
        check("t4_clear_busy", 32'(busy), 32'd0);
        #1;
        check("t4_clear_no_launch", 32'(start_cnt - s0), 32'd1);
        repeat (10) @(negedge clk_100m);
        press_and_start("t4b");
        run_sequence(8'h71, 8'h72, 8'h73, 1'b0);
`else
        et = 0;
        repeat (150) @(negedge clk_100m);
        check("t4_busy_held", 32'(busy), 32'd1);
        check("t4_no_err", 32'(err_timeout), 32'(et));
        finish_run(8'h71, 1, 1'b0, 1'b0);
        finish_run(8'h72, 20, 1'b0, 1'b0);
        finish_run(8'h73, 20, 1'b0, 1'b1);
`endif
        repeat (10) @(negedge clk_100m);

        // 6: asynchronous reset mid-WAIT, then relaunch
        press_and_start("t6");
        repeat (5) @(negedge clk_100m);
        #2 rst_btn_n = 1'b0;
        #1;
        exp_led  = '0;
        exp_runs = 0;
        sb.delete();
        check("t6_rst_cnn_start", 32'(cnn_start), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_led", 32'(led_result), 32'(exp_led));
        check("t6_rst_run_cnt", 32'(run_cnt), 32'(exp_runs));
        check("t6_rst_err", 32'(err_timeout), 32'd0);
        @(negedge clk_100m);
        rst_btn_n = 1'b1;
        repeat (3) @(negedge clk_100m);
        press_and_start("t6b");
        run_sequence(8'h81, 8'h82, 8'h83, 1'b0);
        repeat (10) @(negedge clk_100m);

        // Reset during the launch cycle drops cnn_start without waiting for a clock edge.
        press_and_start("t6c");
        #2 rst_btn_n = 1'b0;
        #1;
        check("t6_async_start_drop", 32'(cnn_start), 32'd0);
        check("t6_async_busy_drop", 32'(busy), 32'd0);
        @(negedge clk_100m);
        rst_btn_n = 1'b1;
        repeat (3) @(negedge clk_100m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
